pacman_mover: RTL and testbench
===============================

// Module: pacman_mover
// PURPOSE
//  Per-frame Pac-Man position engine. Runs in the vblank slot granted by the access arbiter (its pacmanCE drives ce).
//  Once per frame: samples the joystick, checks the maze tile RAM for walls, then commits the new sprite position and direction.
//  Sits downstream of the arbiter and upstream of the sprite renderer, which reads pac_x/pac_y during active video.
// PARAMETERS
//  START_X   112  reset X pixel (tile aligned, multiple of 8)
//  START_Y   184  reset Y pixel (tile aligned)
//  SPEED     1    pixels per frame; legal values 1, 2, 4, 8 (must divide 8)
//  WALL_BIT  7    maze_data bit that marks a wall tile
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  ce         in   1   access grant from arbiter; FSM advances only when 1
//  svpos      in   10  video line counter
//  joy_dir    in   4   {down,up,left,right}, active-high
//  maze_data  in   8   tile byte from sync RAM, 1-cycle read latency
//  maze_addr  out  10  tile address = row*32 + col (32x30 grid)
//  pac_x      out  8   sprite X pixel
//  pac_y      out  8   sprite Y pixel
//  pac_dir    out  2   0=right 1=left 2=up 3=down
//  busy       out  1   high from START until DONE
//  done       out  1   1-cycle pulse when the position is committed
// BEHAVIOUR
//  Reset: pac_x=START_X, pac_y=START_Y, pac_dir=1 (left), maze_addr=0, busy=0, done=0, armed=0, FSM=IDLE.
//  Arming: armed<=1 while svpos<480. Update starts when armed&&ce in IDLE; armed is cleared at start. Result: exactly one update per frame.
//  Desired dir: lowest set bit of joy_dir, sampled on the start cycle. joy_dir==0 -> desired = current dir.
//  FSM: IDLE->LOOK_DES->WAIT_DES->EVAL_DES->[LOOK_CUR->WAIT_CUR->EVAL_CUR]->MOVE->DONE->IDLE.
//  ce=0 in any state other than IDLE: hold state and all registers, including maze_addr. Resume when ce returns.
//  LOOK_*: register maze_addr for the neighbour tile of (pac_x>>3, pac_y>>3) in the tested dir.
//  EVAL_*: sample maze_data (valid 1 clk after WAIT). Wall = maze_data[WALL_BIT].
//  Fast paths (skip lookups, go straight to MOVE):
//   - not tile-aligned (x[2:0]|y[2:0] != 0): move in current dir (or reverse, if desired is the opposite dir).
//   - desired opposite of current: reverse immediately.
//  Aligned: desired free -> pac_dir<=desired, move. Desired walled or == current -> test current dir. Current free -> move. Walled -> stay still (MOVE adds 0).
//  Latency with ce held high: fast path 3 clks start->done; one lookup 6 clks; two lookups 9 clks.
//  MOVE: add or subtract SPEED on the 8-bit axis. DONE: done=1 for one clock, busy=0 on the next.
//  Row out of range (row-1<0 or row+1>29): treated as wall, no RAM access.
//  Column edge (col 0 moving left / col 31 moving right): see CONFIGURATION.
//  joy_dir changes after the start cycle are ignored until the next frame.
//  reset asserted mid-update: immediate return to reset values; no done pulse.
// CONFIGURATION
//  PACMAN_TUNNEL_EN defined:
//   - column lookup wraps mod 32
//   - pac_x wraps mod 256 (255+1 -> 0, 0-1 -> 255)
//  PACMAN_TUNNEL_EN undefined:
//   - column out of range = wall
//   - pac_x never wraps; motion stops at 0 or 248
// TESTING
//  1 Reset: pulse reset -> pac_x=112, pac_y=184, pac_dir=1, busy=0, done=0.
//  2 Free corridor: maze all 0, joy=0, ce=1 after svpos 479->480 -> done pulse once, pac_x=111; second ce in same frame -> no update.
//  3 Turn: at (112,184), joy=up, tile (14,22)=0x80 (wall) -> pac_dir stays 1, pac_x=111; tile clear -> pac_dir=2, pac_y=183.
//  4 Blocked: left and up neighbours walled, joy=up -> position unchanged, done still pulses, 6..9 clks with ce high.
//  5 ce stall: drop ce for 20 clks in WAIT_DES -> maze_addr stable, result identical to the unstalled run.
//  6 Tunnel: pac_x=0, dir left, TUNNEL_EN -> pac_x=255; without TUNNEL_EN -> pac_x stays 0.

Source files
------------

// File: rtl/pacman_mover.sv
// Per-frame Pac-Man position engine: samples the joystick, checks maze walls, commits the move.
// Optional wrap-around tunnel on the left/right edges is enabled by defining PACMAN_TUNNEL_EN.
module pacman_mover #(
  parameter int unsigned START_X  = 112,
  parameter int unsigned START_Y  = 184,
  parameter int unsigned SPEED    = 1,
  parameter int unsigned WALL_BIT = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [9:0] svpos,
  input  logic [3:0] joy_dir,
  input  logic [7:0] maze_data,
  output logic [9:0] maze_addr,
  output logic [7:0] pac_x,
  output logic [7:0] pac_y,
  output logic [1:0] pac_dir,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StLookDes = 4'd1;
  localparam logic [3:0] StWaitDes = 4'd2;
  localparam logic [3:0] StEvalDes = 4'd3;
  localparam logic [3:0] StLookCur = 4'd4;
  localparam logic [3:0] StWaitCur = 4'd5;
  localparam logic [3:0] StEvalCur = 4'd6;
  localparam logic [3:0] StMove    = 4'd7;
  localparam logic [3:0] StDone    = 4'd8;

  localparam logic [1:0] DirRight = 2'd0;
  localparam logic [1:0] DirLeft  = 2'd1;
  localparam logic [1:0] DirUp    = 2'd2;
  localparam logic [1:0] DirDown  = 2'd3;

  localparam logic [7:0] Step = 8'(SPEED);
  localparam logic [7:0] XMax = 8'd248;
  localparam logic [7:0] YMax = 8'd232;

`ifdef PACMAN_TUNNEL_EN
  localparam bit TunnelEn = 1'b1;
`else
  localparam bit TunnelEn = 1'b0;
`endif

  logic [3:0] state_q, state_d;
  logic [7:0] pac_x_q, pac_x_d;
  logic [7:0] pac_y_q, pac_y_d;
  logic [1:0] pac_dir_q, pac_dir_d;
  logic [1:0] des_q, des_d;
  logic       stay_q, stay_d;
  logic       oob_q, oob_d;
  logic       armed_q, armed_d;
  logic [9:0] maze_addr_q, maze_addr_d;

  logic [1:0] joy_des;
  logic       aligned;
  logic       opposite;
  logic       start;
  logic       wall;
  logic [1:0] look_dir;
  logic [4:0] col, row, nb_col, nb_row;
  logic       nb_oob;

  logic unused_maze_bits;
  assign unused_maze_bits = ^maze_data;

  always_comb begin
    if (joy_dir[0])      joy_des = DirRight;
    else if (joy_dir[1]) joy_des = DirLeft;
    else if (joy_dir[2]) joy_des = DirUp;
    else if (joy_dir[3]) joy_des = DirDown;
    else                 joy_des = pac_dir_q;
  end

  assign aligned  = ((pac_x_q[2:0] | pac_y_q[2:0]) == 3'd0);
  // Opposite directions differ only in bit 0 (right/left, up/down).
  assign opposite = ((joy_des ^ 2'b01) == pac_dir_q);
  assign start    = (state_q == StIdle) && armed_q && ce;
  assign wall     = oob_q | maze_data[WALL_BIT];

  assign col      = pac_x_q[7:3];
  assign row      = pac_y_q[7:3];
  assign look_dir = (state_q == StLookCur) ? pac_dir_q : des_q;

  always_comb begin
    nb_col = col;
    nb_row = row;
    nb_oob = 1'b0;
    case (look_dir)
      DirRight: begin
        nb_col = col + 5'd1;
        nb_oob = (col == 5'd31) && !TunnelEn;
      end
      DirLeft: begin
        nb_col = col - 5'd1;
        nb_oob = (col == 5'd0) && !TunnelEn;
      end
      DirUp: begin
        nb_row = row - 5'd1;
        nb_oob = (row == 5'd0);
      end
      default: begin
        nb_row = row + 5'd1;
        nb_oob = (row >= 5'd29);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pac_x_d     = pac_x_q;
    pac_y_d     = pac_y_q;
    pac_dir_d   = pac_dir_q;
    des_d       = des_q;
    stay_d      = stay_q;
    oob_d       = oob_q;
    maze_addr_d = maze_addr_q;

    // Start has priority so a single frame can never trigger two updates.
    if (start)                armed_d = 1'b0;
    else if (svpos < 10'd480) armed_d = 1'b1;
    else                      armed_d = armed_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          des_d  = joy_des;
          stay_d = 1'b0;
          if (!aligned || opposite) begin
            if (opposite) pac_dir_d = joy_des;
            state_d = StMove;
          end else if (joy_des == pac_dir_q) begin
            state_d = StLookCur;
          end else begin
            state_d = StLookDes;
          end
        end
      end
      StLookDes, StLookCur: begin
        if (ce) begin
          oob_d = nb_oob;
          if (!nb_oob) maze_addr_d = {nb_row, nb_col};
          state_d = (state_q == StLookDes) ? StWaitDes : StWaitCur;
        end
      end
      StWaitDes: if (ce) state_d = StEvalDes;
      StWaitCur: if (ce) state_d = StEvalCur;
      StEvalDes: begin
        if (ce) begin
          if (!wall) begin
            pac_dir_d = des_q;
            state_d   = StMove;
          end else begin
            state_d = StLookCur;
          end
        end
      end
      StEvalCur: begin
        if (ce) begin
          stay_d  = wall;
          state_d = StMove;
        end
      end
      StMove: begin
        if (ce) begin
          if (!stay_q) begin
            case (pac_dir_q)
              DirRight: if (TunnelEn || (pac_x_q <= XMax - Step)) pac_x_d = pac_x_q + Step;
              DirLeft:  if (TunnelEn || (pac_x_q >= Step))        pac_x_d = pac_x_q - Step;
              DirUp:    if (pac_y_q >= Step)                      pac_y_d = pac_y_q - Step;
              default:  if (pac_y_q <= YMax - Step)               pac_y_d = pac_y_q + Step;
            endcase
          end
          state_d = StDone;
        end
      end
      StDone:  if (ce) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pac_x_q     <= 8'(START_X);
      pac_y_q     <= 8'(START_Y);
      pac_dir_q   <= DirLeft;
      des_q       <= DirLeft;
      stay_q      <= 1'b0;
      oob_q       <= 1'b0;
      armed_q     <= 1'b0;
      maze_addr_q <= 10'd0;
    end else begin
      state_q     <= state_d;
      pac_x_q     <= pac_x_d;
      pac_y_q     <= pac_y_d;
      pac_dir_q   <= pac_dir_d;
      des_q       <= des_d;
      stay_q      <= stay_d;
      oob_q       <= oob_d;
      armed_q     <= armed_d;
      maze_addr_q <= maze_addr_d;
    end
  end

  assign maze_addr = maze_addr_q;
  assign pac_x     = pac_x_q;
  assign pac_y     = pac_y_q;
  assign pac_dir   = pac_dir_q;
  assign busy      = (state_q != StIdle);
  // Gated by ce so a stalled DONE state still yields a single-cycle pulse.
  assign done      = (state_q == StDone) && ce;

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover: vector table of single-frame moves plus hand-written
// sequences for frame gating, ce stalls, mid-update reset and the left-edge tunnel.
module tb_pacman_mover;

  logic       clk = 1'b0;
  logic       reset, ce;
  logic [9:0] svpos;
  logic [3:0] joy_dir;
  logic [7:0] maze_data;
  logic [9:0] maze_addr;
  logic [7:0] pac_x, pac_y;
  logic [1:0] pac_dir;
  logic       busy, done;

  always #5 clk = ~clk;

  pacman_mover dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .svpos     (svpos),
    .joy_dir   (joy_dir),
    .maze_data (maze_data),
    .maze_addr (maze_addr),
    .pac_x     (pac_x),
    .pac_y     (pac_y),
    .pac_dir   (pac_dir),
    .busy      (busy),
    .done      (done)
  );

  // Tile RAM model with one-cycle read latency.
  logic [7:0] mem [1024];
  always @(posedge clk) maze_data <= mem[maze_addr];

  // Neighbour tile addresses around the start tile (col 14, row 23).
  localparam logic [9:0] AUp    = 10'd718;
  localparam logic [9:0] ALeft  = 10'd749;
  localparam logic [9:0] ARight = 10'd751;
  localparam logic [9:0] ADown  = 10'd782;

`ifdef PACMAN_TUNNEL_EN
  localparam int EdgeX = 255;
`else
  localparam int EdgeX = 0;
`endif

  typedef struct {
    logic [3:0] joy;
    logic [9:0] wall_a;
    logic [9:0] wall_b;
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] dir;
    int         lat;
  } vec_t;

  vec_t vecs [11];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_maze();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ce = 1'b0; svpos = 10'd100; joy_dir = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Active video line arms the block, then vblank begins; ends on a negedge.
  task automatic arm();
    @(negedge clk); svpos = 10'd100; ce = 1'b0;
    @(negedge clk); svpos = 10'd480;
    @(negedge clk);
  endtask

  // Latency counts the start cycle through the done cycle inclusive; -1 on timeout.
  task automatic run_frame(input logic [3:0] j, output int lat);
    arm();
    joy_dir = j; ce = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
    ce = 1'b0; joy_dir = 4'd0;
  endtask

  initial begin
    int  lat;
    int  pulses;
    bit  stable;

    reset = 1'b1; ce = 1'b0; svpos = 10'd0; joy_dir = 4'd0;
    clear_maze();

    vecs[0]  = '{4'b0000, 10'd0, 10'd0,  8'd111, 8'd184, 2'd1, 6};
    vecs[1]  = '{4'b0100, AUp,   10'd0,  8'd111, 8'd184, 2'd1, 9};
    vecs[2]  = '{4'b0100, 10'd0, 10'd0,  8'd112, 8'd183, 2'd2, 6};
    vecs[3]  = '{4'b0100, AUp,   ALeft,  8'd112, 8'd184, 2'd1, 9};
    vecs[4]  = '{4'b0001, ALeft, 10'd0,  8'd113, 8'd184, 2'd0, 3};
    vecs[5]  = '{4'b1000, 10'd0, 10'd0,  8'd112, 8'd185, 2'd3, 6};
    vecs[6]  = '{4'b0010, ALeft, 10'd0,  8'd112, 8'd184, 2'd1, 6};
    vecs[7]  = '{4'b1010, 10'd0, 10'd0,  8'd111, 8'd184, 2'd1, 6};
    vecs[8]  = '{4'b1100, AUp,   10'd0,  8'd111, 8'd184, 2'd1, 9};
    vecs[9]  = '{4'b1000, ADown, 10'd0,  8'd111, 8'd184, 2'd1, 9};
    vecs[10] = '{4'b0001, ARight, 10'd0, 8'd113, 8'd184, 2'd0, 3};

    // Reset state
    do_reset();
    #1;
    check("reset_x", pac_x, 112);
    check("reset_y", pac_y, 184);
    check("reset_dir", pac_dir, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", maze_addr, 0);

    // Single-frame table
    for (int i = 0; i < 11; i++) begin
      do_reset();
      clear_maze();
      if (vecs[i].wall_a != 10'd0) mem[vecs[i].wall_a] = 8'h80;
      if (vecs[i].wall_b != 10'd0) mem[vecs[i].wall_b] = 8'h80;
      run_frame(vecs[i].joy, lat);
      check($sformatf("vec%0d_x", i), pac_x, vecs[i].x);
      check($sformatf("vec%0d_y", i), pac_y, vecs[i].y);
      check($sformatf("vec%0d_dir", i), pac_dir, vecs[i].dir);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // One update per frame, then the off-tile fast path on the next frame
    do_reset();
    clear_maze();
    run_frame(4'b0000, lat);
    check("frame_x", pac_x, 111);
    @(negedge clk); ce = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("second_ce_no_update", pulses, 0);
    check("second_ce_x", pac_x, 111);
    @(negedge clk); ce = 1'b0;
    run_frame(4'b0100, lat);
    check("offtile_x", pac_x, 110);
    check("offtile_y", pac_y, 184);
    check("offtile_dir", pac_dir, 1);
    check("offtile_lat", lat, 3);

    // ce stall inside WAIT_DES
    do_reset();
    clear_maze();
    arm();
    joy_dir = 4'b0100; ce = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ce = 1'b0; joy_dir = 4'b0001;
    check("stall_addr", maze_addr, AUp);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (maze_addr !== AUp || busy !== 1'b1 || done !== 1'b0) stable = 1'b0;
    end
    check("stall_hold", stable, 1);
    ce = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("stall_resume_lat", lat, 3);
    check("stall_x", pac_x, 112);
    check("stall_y", pac_y, 183);
    check("stall_dir", pac_dir, 2);
    @(posedge clk); #1;
    check("done_width", done, 0);
    check("busy_after_done", busy, 0);
    @(negedge clk); ce = 1'b0; joy_dir = 4'd0;

    // Reset in the middle of an update
    do_reset();
    clear_maze();
    arm();
    joy_dir = 4'b0100; ce = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_y", pac_y, 184);
    check("midreset_dir", pac_dir, 1);
    check("midreset_addr", maze_addr, 0);
    @(negedge clk); reset = 1'b0; ce = 1'b0; joy_dir = 4'd0;

    // Walk left to the screen edge, then one more frame at x=0
    do_reset();
    clear_maze();
    for (int f = 0; f < 112; f++) run_frame(4'b0000, lat);
    check("edge_reach_x", pac_x, 0);
    run_frame(4'b0000, lat);
    check("edge_x", pac_x, EdgeX);
    check("edge_dir", pac_dir, 1);
    check("edge_lat", lat, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
